// File: rtl/division_arbiter_if.sv
// division_arbiter_if: request, response and divider buses
// shared between the calculator front-ends and the arbiter.
interface division_arbiter_if #(
  parameter int DW = 4,
  parameter int QW = 8
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [QW-1:0] rsp_q;
  logic          rsp_err;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic          div_start;
  logic [QW-1:0] div_q;
  logic          div_done;
  logic          busy;

  modport master (
    input  req_valid,
    input  req0_a,
    input  req0_b,
    input  req1_a,
    input  req1_b,
    input  rsp_ready,
    input  div_q,
    input  div_done,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_q,
    output rsp_err,
    output div_a,
    output div_b,
    output div_start,
    output busy
  );

  modport slave (
    output req_valid,
    output req0_a,
    output req0_b,
    output req1_a,
    output req1_b,
    output rsp_ready,
    output div_q,
    output div_done,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_q,
    input  rsp_err,
    input  div_a,
    input  div_b,
    input  div_start,
    input  busy
  );
endinterface

// File: rtl/division_arbiter.sv
// division_arbiter: round-robin share of one signed divider
// between keypad (0) and serial (1) requesters.
module division_arbiter #(
  parameter int DW      = 4,
  parameter int QW      = 8,
  parameter int TIMEOUT = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  division_arbiter_if.master   io_bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_rr_ptr;
  logic          r_rr_seen;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_id;
  logic [QW-1:0] r_q;
  logic          r_err;
  logic [TW-1:0] r_timer;

  logic          w_any;
  logic          w_both;
  logic          w_grant;
  logic [1:0]    w_ready;
  logic          w_accept;
  logic [DW-1:0] w_ga;
  logic [DW-1:0] w_gb;
  logic          w_bzero;
  logic          w_tmo;

  // Grant select: a lone requester wins; a tie goes away from the last grant,
  // and to requester 0 when nothing has been granted since reset.
  always_comb begin
    w_any   = |io_bus.req_valid;
    w_both  = &io_bus.req_valid;
    w_grant = 1'b0;
    unique case (1'b1)
      w_both:
        w_grant = r_rr_seen ? ~r_rr_ptr : 1'b0;
      (io_bus.req_valid == 2'b10):
        w_grant = 1'b1;
      default:
        w_grant = 1'b0;
    endcase
  end

  assign w_ga = w_grant ? io_bus.req1_a : io_bus.req0_a;
  assign w_gb = w_grant ? io_bus.req1_b : io_bus.req0_b;

  assign w_ready  = (r_state == S_IDLE && w_any) ?
                    (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_accept = |(io_bus.req_valid & w_ready);
  assign w_bzero  = (w_gb == '0);
  assign w_tmo    = (r_timer == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: zero divisor skips the divider; done beats timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_bzero ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.div_done || w_tmo) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (io_bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, round-robin pointer, timer and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= 1'b0;
      r_rr_seen <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      r_q       <= '0;
      r_err     <= 1'b0;
      r_timer   <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_a       <= w_ga;
        r_b       <= w_gb;
        r_id      <= w_grant;
        r_rr_ptr  <= w_grant;
        r_rr_seen <= 1'b1;
        r_q       <= '0;
        r_err     <= w_bzero;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end
      if (r_state == S_WAIT) begin
        r_timer <= r_timer + TW'(1);
        if (io_bus.div_done) begin
          r_q   <= io_bus.div_q;
          r_err <= 1'b0;
        end else if (w_tmo) begin
          r_q   <= '0;
          r_err <= 1'b1;
        end
      end
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.rsp_valid = (r_state == S_RESP);
  assign io_bus.rsp_id    = r_id;
  assign io_bus.rsp_q     = r_q;
  assign io_bus.rsp_err   = r_err;
  assign io_bus.div_a     = r_a;
  assign io_bus.div_b     = r_b;
  assign io_bus.div_start = (r_state == S_ISSUE);
  assign io_bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_division_arbiter.sv
// tb_division_arbiter: directed checks of the divider arbiter
// against a stub divider with a 12-cycle compute latency.
module tb_division_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  division_arbiter_if #(.DW(4), .QW(8)) bus ();

  division_arbiter #(
    .DW(4),
    .QW(8),
    .TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  int total = 0;
  int bad = 0;
  int n_start = 0;

  logic       stub_en = 1'b1;
  logic       force_done = 1'b0;
  logic [3:0] stub_cnt;
  logic [7:0] sa;
  logic [7:0] sb;
  logic [7:0] sq;

  // stub divider: done lands in the 13th cycle after the start cycle
  always @(posedge clk) begin
    if (rst) stub_cnt <= 4'd0;
    else if (bus.div_start && stub_en) stub_cnt <= 4'd13;
    else if (stub_cnt != 4'd0) stub_cnt <= stub_cnt - 4'd1;
  end

  always @(posedge clk) begin
    if (bus.div_start) n_start <= n_start + 1;
  end

  always_comb begin
    sa = {{4{bus.div_a[3]}}, bus.div_a};
    sb = {{4{bus.div_b[3]}}, bus.div_b};
    sq = 8'h00;
    if (sb != 8'h00) sq = 8'($signed(sa) / $signed(sb));
  end

  assign bus.div_done = (stub_cnt == 4'd1) | force_done;
  assign bus.div_q    = sq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] vld, input logic [3:0] a,
                        input logic [3:0] b, output int cyc);
    if (vld[1]) begin
      bus.req1_a = a;
      bus.req1_b = b;
    end else begin
      bus.req0_a = a;
      bus.req0_b = b;
    end
    bus.req_valid = vld;
    tick();
    bus.req_valid = 2'b00;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b want=00", bus.req_ready); end
    total++; if (bus.div_start !== 1'b0) begin bad++; $display("FAIL rst_div_start got=%b want=0", bus.div_start); end
    total++; if (bus.div_a !== 4'h0) begin bad++; $display("FAIL rst_div_a got=%h want=0", bus.div_a); end
    total++; if (bus.div_b !== 4'h0) begin bad++; $display("FAIL rst_div_b got=%h want=0", bus.div_b); end
    total++; if (bus.rsp_q !== 8'h00) begin bad++; $display("FAIL rst_rsp_q got=%h want=00", bus.rsp_q); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b want=0", bus.rsp_err); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL rst_rsp_id got=%b want=0", bus.rsp_id); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rr();
    int cyc;
    bus.req0_a = 4'd7;
    bus.req0_b = 4'd2;
    bus.req1_a = 4'hA;
    bus.req1_b = 4'd3;
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rr_tie0 got=%b want=01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b10;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 60) begin tick(); cyc++; end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_rsp0_valid got=%b want=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL rr_rsp0_id got=%b want=0", bus.rsp_id); end
    total++; if (bus.rsp_q !== 8'h03) begin bad++; $display("FAIL rr_rsp0_q got=%h want=03", bus.rsp_q); end
    consume();
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL rr_ready1 got=%b want=10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 60) begin tick(); cyc++; end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_rsp1_valid got=%b want=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL rr_rsp1_id got=%b want=1", bus.rsp_id); end
    total++; if (bus.rsp_q !== 8'hFE) begin bad++; $display("FAIL rr_rsp1_q got=%h want=fe", bus.rsp_q); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rr_rsp1_err got=%b want=0", bus.rsp_err); end
    consume();
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rr_tie_next got=%b want=01", bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    int n0;
    n0 = n_start;
    run_op(2'b01, 4'd6, 4'd2, cyc);
    total++; if (cyc != 15) begin bad++; $display("FAIL basic_latency got=%0d want=15", cyc); end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL basic_id got=%b want=0", bus.rsp_id); end
    total++; if (bus.rsp_q !== 8'h03) begin bad++; $display("FAIL basic_q got=%h want=03", bus.rsp_q); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.rsp_err); end
    total++; if (n_start - n0 != 1) begin bad++; $display("FAIL basic_starts got=%0d want=1", n_start - n0); end
    consume();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", bus.busy); end
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL basic_tie got=%b want=10", bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_div_zero();
    int cyc;
    int n0;
    n0 = n_start;
    run_op(2'b10, 4'd5, 4'd0, cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", cyc); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL dz_err got=%b want=1", bus.rsp_err); end
    total++; if (bus.rsp_q !== 8'h00) begin bad++; $display("FAIL dz_q got=%h want=00", bus.rsp_q); end
    total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL dz_id got=%b want=1", bus.rsp_id); end
    total++; if (n_start != n0) begin bad++; $display("FAIL dz_starts got=%0d want=0", n_start - n0); end
    consume();
  endtask

  task automatic test_timeout();
    int cyc;
    int n0;
    stub_en = 1'b0;
    n0 = n_start;
    run_op(2'b01, 4'd6, 4'd3, cyc);
    // accept->ISSUE, ISSUE->WAIT, 20 WAIT cycles, then RESP
    total++; if (cyc != 22) begin bad++; $display("FAIL to_latency got=%0d want=22", cyc); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", bus.rsp_err); end
    total++; if (bus.rsp_q !== 8'h00) begin bad++; $display("FAIL to_q got=%h want=00", bus.rsp_q); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL to_id got=%b want=0", bus.rsp_id); end
    total++; if (n_start - n0 != 1) begin bad++; $display("FAIL to_starts got=%0d want=1", n_start - n0); end
    consume();
    stub_en = 1'b1;
  endtask

  task automatic test_hold();
    int cyc;
    int n0;
    run_op(2'b01, 4'd5, 4'd1, cyc);
    bus.req_valid = 2'b11;
    n0 = n_start;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b want=1", i, bus.rsp_valid); end
      total++; if (bus.rsp_q !== 8'h05) begin bad++; $display("FAIL hold_q[%0d] got=%h want=05", i, bus.rsp_q); end
      total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL hold_err[%0d] got=%b want=0", i, bus.rsp_err); end
      total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL hold_id[%0d] got=%b want=0", i, bus.rsp_id); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL hold_ready[%0d] got=%b want=00", i, bus.req_ready); end
      total++; if (bus.div_a !== 4'd5) begin bad++; $display("FAIL hold_div_a[%0d] got=%h want=5", i, bus.div_a); end
    end
    total++; if (n_start != n0) begin bad++; $display("FAIL hold_starts got=%0d want=0", n_start - n0); end
    bus.req_valid = 2'b00;
    consume();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hold_idle got=%b want=0", bus.busy); end
  endtask

  task automatic test_spurious_reset();
    bit seen;
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sp_busy got=%b want=0", bus.busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL sp_rsp got=%b want=0", bus.rsp_valid); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL sp_rsp2 got=%b want=0", bus.rsp_valid); end
    bus.req0_a = 4'd6;
    bus.req0_b = 4'd2;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mr_busy_wait got=%b want=1", bus.busy); end
    rst = 1'b1;
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b want=0", bus.busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_rsp got=%b want=0", bus.rsp_valid); end
    total++; if (bus.div_a !== 4'h0) begin bad++; $display("FAIL mr_div_a got=%h want=0", bus.div_a); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mr_dropped got=%b want=0", seen); end
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mr_tie got=%b want=01", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req0_a = 4'h0;
    bus.req0_b = 4'h0;
    bus.req1_a = 4'h0;
    bus.req1_b = 4'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_rr();
    test_basic();
    test_div_zero();
    test_timeout();
    test_hold();
    test_spurious_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
